// File: rtl/pipe_sequencer.sv
// Pipeline controller for the 5-stage WISC core: stage load enables, bubbles/flushes,
// HALT drain sequencing and a saturating lost-fetch-cycle counter.
module pipe_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             redirect,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_ID,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] drain_cnt, drain_next;
  logic          halt_accept;

  // HALT is only taken when no higher-priority RUN condition is present
  assign halt_accept = halt_ID && !dmem_stall && !hazard_stall && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      halted    <= (state_next == HALTED);
    end
  end

  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    case (state)
      RUN: begin
        if (halt_accept) begin
          state_next = DRAIN;
          drain_next = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!dmem_stall) begin
          if (drain_cnt != '0) drain_next = drain_cnt - DW'(1);
          if (drain_cnt <= DW'(1)) state_next = HALTED;
        end
      end
      HALTED: state_next = HALTED;
      default: begin
        state_next = RUN;
        drain_next = '0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (rst || state == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dmem_stall) begin
      // Freeze everything up to MEM; WB takes a bubble while memory finishes
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      ifid_flush   = (state == DRAIN);
    end else if (state == DRAIN) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end else if (hazard_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (redirect) begin
      ifid_flush = 1'b1;
    end else if (halt_ID || imem_stall) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Lost fetch cycles while running; saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == RUN && !pc_en && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: constant vector table, directed corner sequences and
// randomized traffic against a behavioural model, on two parameterisations.
module tb_pipe_sequencer;

  localparam int DR_A = 3;
  localparam int MAX_A = 65535;
  localparam int DR_S = 1;
  localparam int MAX_S = 15;

  logic clk = 1'b0;
  logic rst, hazard_stall, redirect, imem_stall, dmem_stall, halt_ID;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble, halted;
  logic [15:0] stall_cnt;
  logic pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_bubble_s, exmem_en_s, memwb_en_s,
        memwb_bubble_s, halted_s;
  logic [3:0] stall_cnt_s;
  logic [7:0] got_a, got_s;

  always #5 clk = ~clk;

  pipe_sequencer dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect(redirect),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_ID(halt_ID),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .memwb_bubble(memwb_bubble), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_sequencer #(.DRAIN_CYCLES(DR_S), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect(redirect),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_ID(halt_ID),
    .pc_en(pc_en_s), .ifid_en(ifid_en_s), .ifid_flush(ifid_flush_s), .idex_en(idex_en_s),
    .idex_bubble(idex_bubble_s), .exmem_en(exmem_en_s), .memwb_en(memwb_en_s),
    .memwb_bubble(memwb_bubble_s), .halted(halted_s), .stall_cnt(stall_cnt_s)
  );

  assign got_a = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble};
  assign got_s = {pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_bubble_s, exmem_en_s,
                  memwb_en_s, memwb_bubble_s};

  // Control vectors: {pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb_en, memwb_bubble}
  localparam logic [7:0] C_IDLE  = 8'b11010110;
  localparam logic [7:0] C_DMEM  = 8'b00000011;
  localparam logic [7:0] C_HAZ   = 8'b00011110;
  localparam logic [7:0] C_REDIR = 8'b11110110;
  localparam logic [7:0] C_FLUSH = 8'b01110110;
  localparam logic [7:0] C_OFF   = 8'b00000000;

  int n_err = 0;
  int n_checks = 0;
  // Model: left<0 running, left>0 edges of drain still owed, left==0 halted
  int left_a, stalls_a, left_s, stalls_s;

  typedef struct {
    string      name;
    logic       hz, rd, im, dm, ht;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_ctl(input int left, input logic r, input logic hz,
                                         input logic rd, input logic im, input logic dm,
                                         input logic ht);
    if (r || left == 0) return C_OFF;
    if (dm) return (left > 0) ? 8'b00100011 : C_DMEM;
    if (left > 0) return C_FLUSH;
    if (hz) return C_HAZ;
    if (rd) return C_REDIR;
    if (ht || im) return C_FLUSH;
    return C_IDLE;
  endfunction

  task automatic m_reset();
    left_a = -1; stalls_a = 0;
    left_s = -1; stalls_s = 0;
  endtask

  task automatic adv(inout int left, inout int stalls, input int dr, input int maxc);
    logic [7:0] c;
    c = exp_ctl(left, 1'b0, hazard_stall, redirect, imem_stall, dmem_stall, halt_ID);
    if (left < 0 && !c[7]) stalls = (stalls < maxc) ? stalls + 1 : maxc;
    if (left < 0 && halt_ID && !dmem_stall && !hazard_stall && !redirect) left = dr;
    else if (left > 0 && !dmem_stall) left--;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctl"}, got_a, exp_ctl(left_a, rst, hazard_stall, redirect, imem_stall, dmem_stall, halt_ID));
    chk({tag, ".halted"}, halted, left_a == 0);
    chk({tag, ".cnt"}, stall_cnt, stalls_a);
    chk({tag, ".ctl_s"}, got_s, exp_ctl(left_s, rst, hazard_stall, redirect, imem_stall, dmem_stall, halt_ID));
    chk({tag, ".halted_s"}, halted_s, left_s == 0);
    chk({tag, ".cnt_s"}, stall_cnt_s, stalls_s);
  endtask

  task automatic drive(input logic hz, input logic rd, input logic im, input logic dm, input logic ht);
    hazard_stall = hz; redirect = rd; imem_stall = im; dmem_stall = dm; halt_ID = ht;
    #2;
  endtask

  // Check mid-cycle, then take one clock edge and advance the model
  task automatic advance(input string tag);
    check_all(tag);
    @(posedge clk);
    adv(left_a, stalls_a, DR_A, MAX_A);
    adv(left_s, stalls_s, DR_S, MAX_S);
    #1;
  endtask

  // Reset asserted and released between edges
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    m_reset();
    check_all(tag);
    chk({tag, ".off"}, got_a, C_OFF);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"idle",      0, 0, 0, 0, 0, C_IDLE};
    tbl[1] = '{"dmem",      0, 0, 0, 1, 0, C_DMEM};
    tbl[2] = '{"dmem_all",  1, 1, 1, 1, 1, C_DMEM};
    tbl[3] = '{"haz",       1, 0, 0, 0, 0, C_HAZ};
    tbl[4] = '{"haz_rd_im", 1, 1, 1, 0, 0, C_HAZ};
    tbl[5] = '{"haz_halt",  1, 0, 0, 0, 1, C_HAZ};
    tbl[6] = '{"redir",     0, 1, 0, 0, 0, C_REDIR};
    tbl[7] = '{"redir_im",  0, 1, 1, 0, 0, C_REDIR};
    tbl[8] = '{"redir_halt",0, 1, 0, 0, 1, C_REDIR};
    tbl[9] = '{"imem",      0, 0, 1, 0, 0, C_FLUSH};

    rst = 1'b1;
    hazard_stall = 0; redirect = 0; imem_stall = 0; dmem_stall = 0; halt_ID = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].hz, tbl[i].rd, tbl[i].im, tbl[i].dm, tbl[i].ht);
      chk({"tbl.", tbl[i].name}, got_a, tbl[i].exp);
      advance({"tbl.", tbl[i].name});
    end

    // Single-cycle hazard stall
    pulse_reset("t1.rst");
    drive(1, 0, 0, 0, 0);
    chk("t1.haz", got_a, C_HAZ);
    chk("t1.cnt0", stall_cnt, 0);
    advance("t1.a");
    drive(0, 0, 0, 0, 0);
    chk("t1.cnt1", stall_cnt, 1);
    chk("t1.idle", got_a, C_IDLE);
    advance("t1.b");

    // dmem stall dominates hazard and redirect
    pulse_reset("t2.rst");
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 1, 0);
      chk("t2.dmem", got_a, C_DMEM);
      advance("t2");
    end
    drive(0, 0, 0, 0, 0);
    chk("t2.cnt", stall_cnt, 4);

    // Redirect overrides imem stall and does not count
    drive(0, 1, 1, 0, 0);
    chk("t3.redir", got_a, C_REDIR);
    advance("t3");
    drive(0, 0, 0, 0, 0);
    chk("t3.cnt", stall_cnt, 4);

    // HALT drain, plain then with dmem stalls inside DRAIN
    pulse_reset("t4.rst");
    drive(0, 0, 0, 0, 1);
    advance("t4.e0");
    drive(0, 0, 0, 0, 0);
    advance("t4.e1");
    advance("t4.e2");
    chk("t4.not_yet", halted, 0);
    drive(1, 1, 1, 0, 1);
    advance("t4.e3");
    chk("t4.halted", halted, 1);
    chk("t4.off", got_a, C_OFF);
    advance("t4.hold");

    pulse_reset("t4b.rst");
    drive(0, 0, 0, 0, 1);
    advance("t4b.e0");
    drive(0, 0, 0, 1, 0);
    advance("t4b.e1");
    advance("t4b.e2");
    drive(0, 0, 0, 0, 0);
    advance("t4b.e3");
    advance("t4b.e4");
    chk("t4b.not_yet", halted, 0);
    advance("t4b.e5");
    chk("t4b.halted", halted, 1);
    chk("t4b.off", got_a, C_OFF);

    // Saturation of the narrow counter
    pulse_reset("t5.rst");
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, 0);
      advance("t5");
    end
    chk("t5.cnt_s", stall_cnt_s, 15);
    chk("t5.cnt", stall_cnt, 20);

    // Reset in the middle of DRAIN
    pulse_reset("t6.pre");
    drive(0, 0, 1, 0, 0);
    advance("t6.stall");
    drive(0, 0, 0, 0, 1);
    advance("t6.e0");
    drive(0, 0, 0, 0, 0);
    advance("t6.e1");
    pulse_reset("t6.rst");
    chk("t6.halted", halted, 0);
    chk("t6.cnt", stall_cnt, 0);
    drive(0, 0, 0, 0, 0);
    chk("t6.idle", got_a, C_IDLE);
    advance("t6.after");

    // Randomized traffic with occasional resets
    begin
      int halt_age;
      halt_age = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 199) == 0 || halt_age > 4) begin
          pulse_reset("rnd.rst");
          halt_age = 0;
        end
        drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
        advance("rnd");
        if (left_a == 0) halt_age++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
